// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector: a Mealy det output plus an optional saturating hit counter.
// The hit counter is built only when SEQ_DETECT_CNT_EN is defined; otherwise hit_cnt reads 0.
module seq_detect_param #(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b001,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             inp,
  input  logic             clr,
  output logic             det,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int FILL_W = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] history;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] window;
  logic               full;

  assign window = {history, inp};
  assign full   = (fill == FILL_MAX);
  assign det    = en & ~clr & full & (window == PATTERN);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      history <= '0;
      fill    <= '0;
    end else if (clr) begin
      history <= '0;
      fill    <= '0;
    end else if (en) begin
      history <= window[PAT_LEN-2:0];
      // Non-overlapping mode restarts the fill so no matched bit is reused.
      if (det && !OVERLAP)
        fill <= '0;
      else if (!full)
        fill <= fill + FILL_W'(1);
    end
  end

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clr)
      cnt_q <= '0;
    else if (det && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign hit_cnt = cnt_q;
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four instances (001/101 patterns, overlap on/off, 2-bit counter)
// checked against a queue-based model of the accepted bit stream.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic inp = 1'b0;
  logic clr = 1'b0;

  logic       det_w [4];
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  always #5 clk = ~clk;

  seq_detect_param u_def (.clk(clk), .reset_n(reset_n), .en(en), .inp(inp), .clr(clr),
                          .det(det_w[0]), .hit_cnt(cnt0));
  seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) u_ovl
                         (.clk(clk), .reset_n(reset_n), .en(en), .inp(inp), .clr(clr),
                          .det(det_w[1]), .hit_cnt(cnt1));
  seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) u_novl
                         (.clk(clk), .reset_n(reset_n), .en(en), .inp(inp), .clr(clr),
                          .det(det_w[2]), .hit_cnt(cnt2));
  seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b001), .OVERLAP(1'b1), .CNT_W(2)) u_sat
                         (.clk(clk), .reset_n(reset_n), .en(en), .inp(inp), .clr(clr),
                          .det(det_w[3]), .hit_cnt(cnt3));

  // Reference model: accepted bits since the last reset/clr (or non-overlapping match).
  bit       q [4][$];
  int       cnt [4];
  bit       exp_det [4];
  int       pats [4] = '{3'b001, 3'b101, 3'b101, 3'b001};
  bit       ovl  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  int       cmax [4] = '{255, 255, 255, 3};
  int       total = 0;
  int       bad = 0;

  function automatic bit model_det(int k);
    int w;
    if (!en || clr || q[k].size() < 2) return 1'b0;
    w = (int'(q[k][q[k].size()-2]) << 2) | (int'(q[k][q[k].size()-1]) << 1) | int'(inp);
    return (w == pats[k]);
  endfunction

  function automatic logic [31:0] got_cnt(int k);
    case (k)
      0:       return {24'b0, cnt0};
      1:       return {24'b0, cnt1};
      2:       return {24'b0, cnt2};
      default: return {30'b0, cnt3};
    endcase
  endfunction

  function automatic logic [31:0] exp_cnt(int k);
`ifdef SEQ_DETECT_CNT_EN
    return cnt[k];
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input bit r, input bit e, input bit i, input bit c);
    @(negedge clk);
    reset_n = r; en = e; inp = i; clr = c;
    #1;
    for (int k = 0; k < 4; k++) exp_det[k] = model_det(k);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (!reset_n || clr) begin
        q[k].delete();
        cnt[k] = 0;
      end else if (en) begin
        if (exp_det[k] && cnt[k] < cmax[k]) cnt[k]++;
        if (exp_det[k] && !ovl[k]) q[k].delete();
        else begin
          q[k].push_back(inp);
          if (q[k].size() > 2) void'(q[k].pop_front());
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 0); tick();
    drive(0, 0, 0, 0); tick();
    drive(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (det_w[k] !== 1'b0) begin
        bad++; $display("FAIL reset_det inst%0d got=%b want=0", k, det_w[k]);
      end
      total++;
      if (got_cnt(k) !== 32'd0) begin
        bad++; $display("FAIL reset_cnt inst%0d got=%0d want=0", k, got_cnt(k));
      end
    end
    tick();
  endtask

  // Steps are {reset_n, en, inp, clr}; every step is checked against the model.
  task automatic test_basic();
    logic [3:0] st [$];
    st = '{4'b0100, 4'b1100, 4'b1100, 4'b1110,
           4'b0100, 4'b1110, 4'b1100, 4'b1100, 4'b1100, 4'b1110,
           4'b0100, 4'b1100, 4'b1100, 4'b1000, 4'b1010, 4'b1000, 4'b1010, 4'b1000, 4'b1110,
           4'b0100, 4'b1100, 4'b1100, 4'b0100, 4'b1110,
           4'b1100, 4'b1100, 4'b1111};
    foreach (st[s]) begin
      drive(st[s][3], st[s][2], st[s][1], st[s][0]);
      for (int k = 0; k < 4; k++) begin
        total++;
        if (det_w[k] !== exp_det[k]) begin
          bad++; $display("FAIL basic_det step%0d inst%0d got=%b want=%b", s, k, det_w[k], exp_det[k]);
        end
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        total++;
        if (got_cnt(k) !== exp_cnt(k)) begin
          bad++; $display("FAIL basic_cnt step%0d inst%0d got=%0d want=%0d", s, k, got_cnt(k), exp_cnt(k));
        end
      end
    end
  endtask

  task automatic test_overlap();
    bit seq   [5] = '{1, 0, 1, 0, 1};
    bit w_ovl [5] = '{0, 0, 1, 0, 1};
    bit w_nov [5] = '{0, 0, 1, 0, 0};
    drive(0, 0, 0, 0); tick();
    for (int s = 0; s < 5; s++) begin
      drive(1, 1, seq[s], 0);
      total++;
      if (det_w[1] !== w_ovl[s] || det_w[1] !== exp_det[1]) begin
        bad++; $display("FAIL ovl_det bit%0d got=%b want=%b", s + 1, det_w[1], w_ovl[s]);
      end
      total++;
      if (det_w[2] !== w_nov[s] || det_w[2] !== exp_det[2]) begin
        bad++; $display("FAIL novl_det bit%0d got=%b want=%b", s + 1, det_w[2], w_nov[s]);
      end
      tick();
    end
`ifdef SEQ_DETECT_CNT_EN
    total++;
    if (cnt1 !== 8'd2) begin bad++; $display("FAIL ovl_cnt got=%0d want=2", cnt1); end
    total++;
    if (cnt2 !== 8'd1) begin bad++; $display("FAIL novl_cnt got=%0d want=1", cnt2); end
`endif
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 0); tick();
    for (int s = 0; s < 15; s++) begin
      drive(1, 1, (s % 3) == 2, 0);
      total++;
      if (det_w[3] !== exp_det[3]) begin
        bad++; $display("FAIL b2b_det step%0d got=%b want=%b", s, det_w[3], exp_det[3]);
      end
      tick();
    end
    total++;
    if (got_cnt(3) !== exp_cnt(3)) begin
      bad++; $display("FAIL b2b_sat got=%0d want=%0d", got_cnt(3), exp_cnt(3));
    end
`ifdef SEQ_DETECT_CNT_EN
    total++;
    if (cnt3 !== 2'd3) begin bad++; $display("FAIL b2b_sat_const got=%0d want=3", cnt3); end
`endif
    drive(1, 1, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    drive(1, 1, 1, 1);
    total++;
    if (det_w[3] !== 1'b0) begin bad++; $display("FAIL clr_det got=%b want=0", det_w[3]); end
    tick();
    total++;
    if (cnt3 !== 2'd0) begin bad++; $display("FAIL clr_cnt got=%0d want=0", cnt3); end
  endtask

  task automatic test_random();
    bit r, e, i, c;
    for (int s = 0; s < 400; s++) begin
      r = ($urandom_range(63) != 0);
      e = ($urandom_range(3) != 0);
      i = $urandom_range(1);
      c = ($urandom_range(31) == 0);
      drive(r, e, i, c);
      for (int k = 0; k < 4; k++) begin
        total++;
        if (det_w[k] !== exp_det[k]) begin
          bad++; $display("FAIL rand_det step%0d inst%0d got=%b want=%b", s, k, det_w[k], exp_det[k]);
        end
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        total++;
        if (got_cnt(k) !== exp_cnt(k)) begin
          bad++; $display("FAIL rand_cnt step%0d inst%0d got=%0d want=%0d", s, k, got_cnt(k), exp_cnt(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
